inst_fetch: RTL
===============

# inst_fetch

Instruction fetch unit: the requesting side of the synchronous instruction ROM. Holds the program counter, drives the ROM address, and pairs each returned word, which arrives one cycle later, with its PC. It buffers up to two fetched instructions for the decode stage behind a valid/ready handshake, and applies branch/jump redirects with a flush.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset
- PC_STEP, 4, byte increment between sequential fetches
- clk_50  in  1  single clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- mem_addr  out  32  ROM address; equals the internal fetch_pc register, not gated
- mem_inst  in  32  ROM data; valid in the cycle after the edge that sampled mem_addr
- redirect_valid  in  1  flush and restart fetch at redirect_pc
- redirect_pc  in  32  redirect target; bits [1:0] ignored and forced to 0
- id_ready  in  1  decode accepts if_inst/if_pc this cycle
- if_valid  out  1  if_inst/if_pc hold a valid instruction
- if_inst  out  32  instruction word (FIFO head)
- if_pc  out  32  address of if_inst
- halted  out  1  fetch stopped on a zero word (only with macro, see Configuration)

## Operation
- State:
  - fetch_pc (32 bits)
  - inflight_v plus inflight_pc (one outstanding ROM read)
  - 2-entry FIFO of {pc, inst} with count 0..2
  - halt flag
- pop = if_valid & id_ready. push = inflight_v & !redirect_valid.
- issue = !redirect_valid & !halt & (count + inflight_v - pop < 2).
- On issue:
  - inflight_v <= 1, inflight_pc <= fetch_pc.
  - fetch_pc <= fetch_pc + PC_STEP, wrapping modulo 2^32.
- With no issue: inflight_v <= 0 and fetch_pc holds. mem_addr is still presented, and the ROM read result is discarded.
- On push: {inflight_pc, mem_inst} is written at the FIFO tail.
- Push and pop in the same cycle: the count is unchanged and ordering is preserved.
- Redirect has priority over everything else:
  - count <= 0 and inflight_v <= 0.
  - fetch_pc <= {redirect_pc[31:2], 2'b00}.
  - The halt flag is cleared.
  - A same-cycle pop is still considered consumed by decode; the flush discards the remaining contents.
- The credit rule guarantees the FIFO never overflows. A push into a full FIFO is unreachable and is checked by assertion.
- if_valid = (count != 0). if_inst and if_pc come from the FIFO head.
- if_inst and if_pc are 0 when count == 0.

## Timing
- Reset (rst_n low, asynchronous):
  - fetch_pc = RESET_PC, inflight_v = 0, count = 0, halt = 0.
  - if_valid = 0, if_inst = 0, if_pc = 0, halted = 0, mem_addr = RESET_PC.
- Edges are numbered from the first rising edge with rst_n high.
  - Edge 1 issues RESET_PC.
  - Edge 2 pushes it.
  - if_valid rises after edge 2 with if_pc = RESET_PC.
- Redirect sampled at edge r:
  - if_valid is low after r.
  - The target is issued at r+1 and pushed at r+2.
  - if_valid is high after r+2 with if_pc = target. The redirect penalty is 2 bubbles.
- Steady state with id_ready held high: one instruction per cycle, with count = 1 and inflight_v = 1 every cycle.
- id_ready low:
  - Fill to count = 2, then issue stops.
  - fetch_pc freezes at head_pc + 2*PC_STEP.
  - No word is lost or duplicated.
- rst_n asserted mid-operation clears all state immediately. The in-flight read is dropped.

## Configuration
- IF_HALT_ON_ZERO_EN defined:
  - A push whose mem_inst == 32'h0000_0000 (end-of-program filler) is not written to the FIFO.
  - Instead, halt <= 1 and issue is inhibited.
  - Instructions already buffered still drain to decode.
  - halted = halt. halted is sticky until redirect or reset.
- IF_HALT_ON_ZERO_EN undefined:
  - Zero words pass through as ordinary instructions.
  - halt stays 0 and halted is tied 0.

## Test plan
- Reset release with id_ready = 1 and a ROM model returning addr^32'hA5A5_0000: if_valid rises after edge 2, then if_pc = 0, 4, 8, ... on consecutive cycles, each with the matching if_inst.
- id_ready = 0 from cycle 3 to cycle 10, then 1: FIFO holds pc 0 and 4, mem_addr freezes at 8, and on release the sequence resumes 0, 4, 8 with no gaps or repeats.
- redirect_valid with redirect_pc = 32'h0000_0057 while count = 2: if_valid is low for 2 cycles, then if_pc = 32'h54, then 32'h58.
- Redirect in the same cycle as a pop and an in-flight push: the in-flight word is discarded, and the next valid PC is the target.
- fetch_pc = 32'hFFFF_FFFC: the next issue is 32'h0000_0000.
- With IF_HALT_ON_ZERO_EN, the ROM returns 0 at addr 164: the instruction at addr 160 is delivered, then halted = 1 and if_valid = 0; a redirect to 0 clears halted and fetch restarts at 0.

Source files
------------

// File: rtl/inst_fetch.sv
`default_nettype none
// ============================================================================
// Module   : inst_fetch
// Purpose  : Requests words from the synchronous instruction ROM and buffers up to
//            two {pc, inst} pairs for decode. Supports branch/jump redirect.
// Option   : IF_HALT_ON_ZERO_EN - stop fetching when an all-zero word returns
// Revision : 1.0 - initial release
// ============================================================================
module inst_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] PC_STEP  = 32'd4
) (
   input  logic        clk_50,
   input  logic        rst_n,
   output logic [31:0] mem_addr,
   input  logic [31:0] mem_inst,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        id_ready,
   output logic        if_valid,
   output logic [31:0] if_inst,
   output logic [31:0] if_pc,
   output logic        halted
);

   logic [31:0] r_fetch_pc;
   logic        r_inflight_v;
   logic [31:0] r_inflight_pc;
   logic [1:0]  r_count;
   logic        r_head;
   logic [31:0] r_fifo_pc   [2];
   logic [31:0] r_fifo_inst [2];

   logic        w_pop;
   logic        w_push;
   logic        w_issue;
   logic        w_tail;
   logic [2:0]  w_occ;
   logic        w_halt_set;
   logic        w_halted;
   logic        w_unused_ok;

   assign w_unused_ok = &{1'b0, redirect_pc[1:0]};

`ifdef IF_HALT_ON_ZERO_EN
   logic r_halt;

   // A zero word marks the end of the program: it is dropped rather than buffered.
   assign w_halt_set = r_inflight_v & (mem_inst == 32'h0000_0000);

   always_ff @(posedge clk_50 or negedge rst_n) begin
      if (!rst_n)
         r_halt <= 1'b0;
      else if (redirect_valid)
         r_halt <= 1'b0;
      else if (w_halt_set)
         r_halt <= 1'b1;
   end

   assign w_halted = r_halt;
`else
   assign w_halt_set = 1'b0;
   assign w_halted   = 1'b0;
`endif

   assign w_pop  = (r_count != 2'd0) & id_ready;
   assign w_push = r_inflight_v & ~redirect_valid & ~w_halt_set & ~w_halted;
   assign w_tail = r_head ^ r_count[0];

   // Occupancy after this edge counting the outstanding read; never exceeds 2.
   assign w_occ   = {1'b0, r_count} + {2'b00, r_inflight_v} - {2'b00, w_pop};
   assign w_issue = ~redirect_valid & ~w_halted & ~w_halt_set & (w_occ < 3'd2);

   always_ff @(posedge clk_50 or negedge rst_n) begin
      if (!rst_n) begin
         r_fetch_pc    <= RESET_PC;
         r_inflight_v  <= 1'b0;
         r_inflight_pc <= 32'h0000_0000;
         r_count       <= 2'd0;
         r_head        <= 1'b0;
      end else if (redirect_valid) begin
         r_fetch_pc   <= {redirect_pc[31:2], 2'b00};
         r_inflight_v <= 1'b0;
         r_count      <= 2'd0;
         r_head       <= 1'b0;
      end else begin
         r_inflight_v <= w_issue;
         if (w_issue) begin
            r_inflight_pc <= r_fetch_pc;
            r_fetch_pc    <= r_fetch_pc + PC_STEP;
         end
         if (w_pop)
            r_head <= ~r_head;
         r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
      end
   end

   always_ff @(posedge clk_50) begin
      if (w_push) begin
         r_fifo_pc[w_tail]   <= r_inflight_pc;
         r_fifo_inst[w_tail] <= mem_inst;
      end
   end

   a_no_overflow: assert property (@(posedge clk_50) disable iff (!rst_n)
      !(w_push && (r_count == 2'd2)));

   assign mem_addr = r_fetch_pc;
   assign if_valid = (r_count != 2'd0);
   assign if_inst  = if_valid ? r_fifo_inst[r_head] : 32'h0000_0000;
   assign if_pc    = if_valid ? r_fifo_pc[r_head]   : 32'h0000_0000;
   assign halted   = w_halted;

endmodule
`default_nettype wire
